// File: rtl/mesh_pkt_pkg.sv
// Packet format shared by mesh terminals: field widths, offsets, header struct and packer.
// Layout, MSB first: nxt_jump[8] | row[4] | col[4] | mode[1] | payload.
package mesh_pkt_pkg;

  localparam int NXT_JUMP_W = 8;
  localparam int ROW_W      = 4;
  localparam int COL_W      = 4;
  localparam int MODE_W     = 1;
  localparam int HDR_W      = NXT_JUMP_W + ROW_W + COL_W + MODE_W;

  typedef struct packed {
    logic [NXT_JUMP_W-1:0] nxt_jump;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col;
    logic                  mode;
  } pkt_t;

  function automatic int hdr_lsb(input int pkt_w);
    return pkt_w - HDR_W;
  endfunction

  function automatic int row_lsb(input int pkt_w);
    return pkt_w - NXT_JUMP_W - ROW_W;
  endfunction

  function automatic int col_lsb(input int pkt_w);
    return pkt_w - NXT_JUMP_W - ROW_W - COL_W;
  endfunction

  // A packet addressed to ourselves would loop in the mesh, so its coordinates are swapped.
  function automatic pkt_t pack_pkt(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                                    input logic mode, input logic [ROW_W-1:0] self_row,
                                    input logic [COL_W-1:0] self_col);
    pkt_t p;
    p.nxt_jump = '0;
    p.mode     = mode;
    if (row == self_row && col == self_col) begin
      p.row = self_col;
      p.col = self_row;
    end else begin
      p.row = row;
      p.col = col;
    end
    return p;
  endfunction

endpackage

// File: rtl/term_fifo.sv
// Synchronous FIFO with combinational head output; pushes while full are dropped.
// DEPTH must be a power of two so the pointers wrap naturally.
module term_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/mesh_terminal_agent.sv
// Edge terminal of the router mesh: queues formatted TX packets and drains/counts RX packets.
// Define MON_CHECK_EN to flag received packets whose row/col is not this terminal (rx_err).
module mesh_terminal_agent
  import mesh_pkt_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int SELF_ROW   = 0,
  parameter int SELF_COL   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stim_valid,
  output logic                 stim_ready,
  input  logic [3:0]           stim_row,
  input  logic [3:0]           stim_col,
  input  logic                 stim_mode,
  input  logic [pckg_sz-18:0]  stim_payload,
  output logic                 pndng,
  output logic [pckg_sz-1:0]   data_out,
  input  logic                 pop,
  input  logic                 pndng_i_in,
  input  logic [pckg_sz-1:0]   data_out_i_in,
  output logic                 popin,
  output logic                 rx_valid,
  output logic [pckg_sz-1:0]   rx_data,
  output logic [15:0]          tx_count,
  output logic [15:0]          rx_count,
  output logic                 rx_err
);

  if (SELF_ROW > ROWS + 1 || SELF_COL > COLUMS + 1 || fifo_depth < 2) begin : g_bad_cfg
    $error("mesh_terminal_agent: illegal coordinate or FIFO depth");
  end

  logic [pckg_sz-1:0] push_data;
  logic [pckg_sz-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;

  assign push_data = {pack_pkt(stim_row, stim_col, stim_mode, 4'(SELF_ROW), 4'(SELF_COL)),
                      stim_payload};

  term_fifo #(
    .WIDTH (pckg_sz),
    .DEPTH (fifo_depth)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (stim_valid),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign stim_ready = !fifo_full;
  assign pndng      = !fifo_empty;
  assign data_out   = pndng ? fifo_head : '0;
  assign popin      = pndng_i_in;

  always_ff @(posedge clk) begin
    if (!reset) tx_count <= '0;
    else if (pop && pndng) tx_count <= tx_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_count <= '0;
    end else begin
      rx_valid <= popin;
      if (popin) begin
        rx_data  <= data_out_i_in;
        rx_count <= rx_count + 16'd1;
      end
    end
  end

`ifdef MON_CHECK_EN
  // Checked from the captured packet, so the flag lands one cycle after rx_valid.
  always_ff @(posedge clk) begin
    if (!reset) rx_err <= 1'b0;
    else if (rx_valid && (rx_data[row_lsb(pckg_sz) +: ROW_W] != 4'(SELF_ROW) ||
                          rx_data[col_lsb(pckg_sz) +: COL_W] != 4'(SELF_COL)))
      rx_err <= 1'b1;
  end
`else
  assign rx_err = 1'b0;
`endif

endmodule

// File: tb/tb_mesh_terminal_agent.sv
// Self-checking bench: directed cases plus randomized traffic against a queue-based model.
module tb_mesh_terminal_agent;

  localparam logic [3:0] SR = 4'd0;
  localparam logic [3:0] SC = 4'd1;
`ifdef MON_CHECK_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stim_valid;
  logic        stim_ready;
  logic [3:0]  stim_row;
  logic [3:0]  stim_col;
  logic        stim_mode;
  logic [22:0] stim_payload;
  logic        pndng;
  logic [39:0] data_out;
  logic        pop;
  logic        pndng_i_in;
  logic [39:0] data_out_i_in;
  logic        popin;
  logic        rx_valid;
  logic [39:0] rx_data;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic        rx_err;

  always #5 clk = ~clk;

  mesh_terminal_agent #(
    .ROWS(4), .COLUMS(4), .pckg_sz(40), .fifo_depth(4), .SELF_ROW(0), .SELF_COL(1)
  ) dut (
    .clk(clk), .reset(reset), .stim_valid(stim_valid), .stim_ready(stim_ready),
    .stim_row(stim_row), .stim_col(stim_col), .stim_mode(stim_mode),
    .stim_payload(stim_payload), .pndng(pndng), .data_out(data_out), .pop(pop),
    .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_count(tx_count), .rx_count(rx_count),
    .rx_err(rx_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [39:0] m_q [$];
  logic [15:0] m_tx_count = '0;
  logic [15:0] m_rx_count = '0;
  logic        m_rx_valid = 1'b0;
  logic [39:0] m_rx_data  = '0;
  logic        m_rx_err   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] mk_pkt(input logic [3:0] r, input logic [3:0] c,
                                         input logic m, input logic [22:0] pl);
    if (r == SR && c == SC) return {8'h00, SC, SR, m, pl};
    return {8'h00, r, c, m, pl};
  endfunction

  task automatic model_update();
    bit do_pop;
    bit do_push;
    if (!reset) begin
      m_q.delete();
      m_tx_count = '0;
      m_rx_count = '0;
      m_rx_valid = 1'b0;
      m_rx_data  = '0;
      m_rx_err   = 1'b0;
      return;
    end
    do_pop  = pop && (m_q.size() > 0);
    do_push = stim_valid && (m_q.size() < 4);
    if (do_pop) begin
      $display("tx pop  %h tx_count=%0d", m_q[0], m_tx_count + 16'd1);
      void'(m_q.pop_front());
      m_tx_count = m_tx_count + 16'd1;
    end
    if (do_push) m_q.push_back(mk_pkt(stim_row, stim_col, stim_mode, stim_payload));
    if (MON && m_rx_valid && (m_rx_data[31:28] != SR || m_rx_data[27:24] != SC))
      m_rx_err = 1'b1;
    m_rx_valid = pndng_i_in;
    if (pndng_i_in) begin
      m_rx_data  = data_out_i_in;
      m_rx_count = m_rx_count + 16'd1;
      $display("rx recv %h rx_count=%0d", data_out_i_in, m_rx_count);
    end
  endtask

  // Called at a falling edge with inputs set: check, update model, advance one cycle.
  task automatic step();
    #1;
    chk("stim_ready", stim_ready, m_q.size() < 4);
    chk("pndng", pndng, m_q.size() > 0);
    chk("data_out", data_out, (m_q.size() > 0) ? m_q[0] : 40'h0);
    chk("popin", popin, pndng_i_in);
    chk("rx_valid", rx_valid, m_rx_valid);
    chk("rx_data", rx_data, m_rx_data);
    chk("tx_count", tx_count, m_tx_count);
    chk("rx_count", rx_count, m_rx_count);
    chk("rx_err", rx_err, m_rx_err);
    model_update();
    @(negedge clk);
  endtask

  task automatic push_pkt(input logic [3:0] r, input logic [3:0] c, input logic m,
                          input logic [22:0] pl);
    stim_row = r; stim_col = c; stim_mode = m; stim_payload = pl; stim_valid = 1'b1;
    step();
    stim_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;
    reset = 1'b0; stim_valid = 1'b0; stim_row = '0; stim_col = '0; stim_mode = 1'b0;
    stim_payload = '0; pop = 1'b0; pndng_i_in = 1'b0; data_out_i_in = '0;
    @(negedge clk);
    step();
    reset = 1'b1;
    chk("rst_pndng", pndng, 1'b0);
    chk("rst_ready", stim_ready, 1'b1);
    chk("rst_data_out", data_out, 40'h0);

    // 1: basic push
    push_pkt(4'd2, 4'd3, 1'b1, 23'h5);
    chk("t1_pndng", pndng, 1'b1);
    chk("t1_data", data_out, 40'h00_2380_0005);
    // 2: self-addressed push lands behind it
    push_pkt(SR, SC, 1'b0, 23'h7);
    pop = 1'b1; step(); pop = 1'b0;
    chk("t2_self", data_out, 40'h00_1000_0007);
    pop = 1'b1; step(); pop = 1'b0;

    // 3: overflow, then drain in order
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_pkt(4'(i), 4'd2, 1'b0, 23'(16 + i));
      if (i == 3) chk("t3_ready_full", stim_ready, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", data_out, {8'h00, 4'(i), 4'd2, 1'b0, 23'(16 + i)});
      pop = 1'b1; step(); pop = 1'b0;
    end
    chk("t3_tx_count", tx_count, 16'd4);
    chk("t3_pndng", pndng, 1'b0);

    // 4: back-to-back receive
    pndng_i_in = 1'b1; data_out_i_in = 40'hAB;
    for (int i = 0; i < 3; i++) begin
      chk("t4_popin", popin, 1'b1);
      step();
      chk("t4_rx_valid", rx_valid, 1'b1);
    end
    pndng_i_in = 1'b0;
    step();
    chk("t4_rx_count", rx_count, 16'd3);
    chk("t4_rx_pulse_end", rx_valid, 1'b0);

    // 5: misaddressed packet
    pndng_i_in = 1'b1; data_out_i_in = {8'h00, 4'd2, SC, 1'b0, 23'h0};
    step();
    pndng_i_in = 1'b0;
    step(); step();
    chk("t5_rx_err", rx_err, MON);

    // 6: reset with packets queued
    push_pkt(4'd3, 4'd3, 1'b0, 23'h11);
    push_pkt(4'd4, 4'd2, 1'b1, 23'h22);
    reset = 1'b0; step(); reset = 1'b1;
    chk("t6_pndng", pndng, 1'b0);
    chk("t6_tx_count", tx_count, 16'd0);
    chk("t6_ready", stim_ready, 1'b1);
    chk("t6_rx_err", rx_err, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom();
      reset        = ($urandom_range(0, 49) != 0);
      stim_valid   = rnd[0] | rnd[1];
      pop          = rnd[2] & (rnd[3] | rnd[4]);
      pndng_i_in   = rnd[5];
      stim_mode    = rnd[6];
      stim_row     = 4'($urandom_range(0, 3));
      stim_col     = 4'($urandom_range(0, 3));
      rnd = $urandom();
      stim_payload = rnd[22:0];
      rnd = $urandom();
      data_out_i_in = {8'h00, (rnd[0] ? SR : rnd[7:4]), (rnd[1] ? SC : rnd[11:8]),
                       rnd[12], rnd[31:9]};
      step();
    end
    reset = 1'b1; stim_valid = 1'b0; pop = 1'b0; pndng_i_in = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
